// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and default sizes for the memory
// access sequencer.
package mem_seq_pkg;

  localparam int ADDR_W_D = 32;
  localparam int DATA_W_D = 32;
  localparam int LAT_D    = 5;
  localparam int CNT_W_D  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_access_seq_lat_counter.sv
// lat_counter: access latency counter, starts at 1 on load,
// holds on stop, flags done when the count reaches LAT.
import mem_seq_pkg::*;

module lat_counter #(
  parameter int LAT   = LAT_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             stop,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= CNT_W'(1);
    end else if (load) begin
      r_cnt <= CNT_W'(1);
    end else if (!stop) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign count = r_cnt;
  assign done  = (r_cnt == CNT_W'(LAT));

endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: one-at-a-time memory request sequencer.
// MEMSEQ_WRITE_FAST_EN: writes skip WAIT and respond from ISSUE.
import mem_seq_pkg::*;

module mem_access_seq #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int LAT    = LAT_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata
);

  if (LAT < 1 || LAT > (2**CNT_W) - 1) begin : g_lat_chk
    $error("mem_access_seq: LAT does not fit CNT_W");
  end

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rsp_write;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_done;
  logic              w_load;
  logic              w_stop;
  logic              w_hs;
  logic              w_rsp_ld;
  logic [DATA_W-1:0] w_rsp_data;

  assign req_ready = (r_state == IDLE);
  assign w_hs      = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_rsp_ld   = 1'b0;
    w_rsp_data = r_write ? '0 : mem_rdata;
    unique case (r_state)
      IDLE: begin
        if (req_valid) w_next = ISSUE;
      end
      ISSUE: begin
        if (!mem_stall) begin
`ifdef MEMSEQ_WRITE_FAST_EN
          if (r_write) begin
            w_next   = RESP;
            w_rsp_ld = 1'b1;
          end else begin
            w_next = WAIT;
            w_load = 1'b1;
          end
`else
          w_next = WAIT;
          w_load = 1'b1;
`endif
        end
      end
      WAIT: begin
        // a stall outranks the final-count exit
        if (!mem_stall && w_done) begin
          w_next   = RESP;
          w_rsp_ld = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_stop = (r_state != WAIT) | mem_stall | w_done;

  lat_counter #(
    .LAT   (LAT),
    .CNT_W (CNT_W)
  ) u_lat (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .stop  (w_stop),
    .count (w_cnt),
    .done  (w_done)
  );

  always_comb begin
    if (rst) assert (w_cnt != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_rdata     <= '0;
      r_rsp_write <= 1'b0;
    end else begin
      if (w_hs) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
      end
      if (w_rsp_ld) begin
        r_rdata     <= w_rsp_data;
        r_rsp_write <= r_write;
      end
    end
  end

  assign mem_cs    = (r_state == ISSUE);
  assign mem_we    = mem_cs & r_write;
  assign mem_addr  = mem_cs ? r_addr : '0;
  assign mem_wdata = mem_cs ? r_wdata : '0;
  assign rsp_valid = (r_state == RESP);
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed checks of the sequencer with
// LAT=5, CNT_W=4.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_stall = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_seq #(
    .ADDR_W (32),
    .DATA_W (32),
    .LAT    (5),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata)
  );

  // Stimulus only: cycle k is the k-th cycle after the handshake
  // edge; k=0 is the ISSUE cycle.
  task automatic run(
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    input  int          stall_at,
    input  int          stall_len,
    input  int          final_idx,
    output int          lat,
    output int          cs_n,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        rwr_o,
    output logic [3:0]  cnt_o
  );
    lat = -1;
    cs_n = 0;
    we_o = 1'b0;
    addr_o = '0;
    wdata_o = '0;
    rdata_o = '0;
    rwr_o = 1'b0;
    cnt_o = '0;
    rsp_ready = 1'b1;
    req_write = wr;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      mem_stall = (k >= stall_at) && (k < stall_at + stall_len);
      mem_rdata = (k == final_idx) ? rd : (32'hBAD0_0000 + k);
      @(negedge clk);
      if (mem_cs) begin
        cs_n++;
        we_o = mem_we;
        addr_o = mem_addr;
        wdata_o = mem_wdata;
      end
      if (stall_len > 0 && k == stall_at + stall_len - 1)
        cnt_o = dut.w_cnt;
      if (rsp_valid) begin
        lat = k;
        rdata_o = rsp_rdata;
        rwr_o = rsp_write;
      end
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);
    end
    checks++;
    if (mem_cs !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mem_cmd got=%b%b exp=00", mem_cs, mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_write);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready_noeffect got=%b%b exp=10", req_ready, rsp_valid);
    end
  endtask

  task automatic test_read();
    int lat, cs_n;
    logic we, rwr;
    logic [31:0] a, wd, rdv;
    logic [3:0] c;
    run(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 99, 0, 5,
        lat, cs_n, we, a, wd, rdv, rwr, c);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL read_latency got=%0d exp=6", lat);
    end
    checks++;
    if (cs_n !== 1 || we !== 1'b0 || a !== 32'h100) begin
      failures++;
      $display("FAIL read_cmd got=cs%0d we%b a%h exp=cs1 we0 a100", cs_n, we, a);
    end
    checks++;
    if (rdv !== 32'hDEADBEEF || rwr !== 1'b0) begin
      failures++;
      $display("FAIL read_rsp got=%h/%b exp=deadbeef/0", rdv, rwr);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_idle got=%b%b exp=10", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_retain got=%h exp=deadbeef", rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_stall();
    int lat, cs_n;
    logic we, rwr;
    logic [31:0] a, wd, rdv;
    logic [3:0] c;
    run(1'b0, 32'h104, 32'h0, 32'h0BADF00D, 2, 3, 8,
        lat, cs_n, we, a, wd, rdv, rwr, c);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL wstall_latency got=%0d exp=9", lat);
    end
    checks++;
    if (c !== 4'd2) begin
      failures++;
      $display("FAIL wstall_cnt_hold got=%0d exp=2", c);
    end
    checks++;
    if (rdv !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL wstall_rdata got=%h exp=0badf00d", rdv);
    end
  endtask

  task automatic test_issue_stall();
    int lat, cs_n;
    logic we, rwr;
    logic [31:0] a, wd, rdv;
    logic [3:0] c;
    run(1'b0, 32'h108, 32'h0, 32'h13579BDF, 0, 2, 7,
        lat, cs_n, we, a, wd, rdv, rwr, c);
    checks++;
    if (cs_n !== 3) begin
      failures++;
      $display("FAIL istall_cs_cycles got=%0d exp=3", cs_n);
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL istall_latency got=%0d exp=8", lat);
    end
    checks++;
    if (rdv !== 32'h13579BDF || a !== 32'h108) begin
      failures++;
      $display("FAIL istall_data got=%h/%h exp=13579bdf/108", rdv, a);
    end
  endtask

  task automatic test_write();
    int lat, cs_n, exp_lat;
    logic we, rwr;
    logic [31:0] a, wd, rdv;
    logic [3:0] c;
`ifdef MEMSEQ_WRITE_FAST_EN
    exp_lat = 1;
`else
    exp_lat = 6;
`endif
    run(1'b1, 32'h20, 32'h55AA, 32'hFFFF_FFFF, 99, 0, 5,
        lat, cs_n, we, a, wd, rdv, rwr, c);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=%0d", lat, exp_lat);
    end
    checks++;
    if (cs_n !== 1 || we !== 1'b1) begin
      failures++;
      $display("FAIL write_cmd got=cs%0d we%b exp=cs1 we1", cs_n, we);
    end
    checks++;
    if (a !== 32'h20 || wd !== 32'h55AA) begin
      failures++;
      $display("FAIL write_bus got=%h/%h exp=20/55aa", a, wd);
    end
    checks++;
    if (rwr !== 1'b1 || rdv !== 32'h0) begin
      failures++;
      $display("FAIL write_rsp got=%b/%h exp=1/0", rwr, rdv);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad_ready, bad_hold, done_k;
    lat = -1;
    bad_ready = 0;
    bad_hold = 0;
    done_k = -1;
    rsp_ready = 1'b0;
    req_write = 1'b0;
    req_addr = 32'h40;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h44;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      mem_rdata = (k == 5) ? 32'hCAFEF00D : (32'hBAD0_0000 + k);
      @(negedge clk);
      if (req_ready !== 1'b0) bad_ready++;
      if (rsp_valid) lat = k;
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL b2b_latency got=%0d exp=6", lat);
    end
    for (int h = 0; h < 3; h++) begin
      mem_rdata = 32'h1111_0000 + h;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) bad_hold++;
      if (req_ready !== 1'b0) bad_ready++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) bad_hold++;
    if (req_ready !== 1'b0) bad_ready++;
    checks++;
    if (bad_hold !== 0) begin
      failures++;
      $display("FAIL b2b_rsp_stable got=%0d exp=0 bad cycles", bad_hold);
    end
    checks++;
    if (bad_ready !== 0) begin
      failures++;
      $display("FAIL b2b_req_ready_low got=%0d exp=0 bad cycles", bad_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b%b exp=10", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 32'h44) begin
      failures++;
      $display("FAIL b2b_second_issue got=%b/%h exp=1/44", mem_cs, mem_addr);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) done_k = k;
    end
    @(posedge clk); #1;
    checks++;
    if (done_k < 0) begin
      failures++;
      $display("FAIL b2b_second_rsp got=timeout exp=response");
    end
  endtask

  task automatic test_reset_mid_wait();
    int stale;
    stale = 0;
    rsp_ready = 1'b1;
    req_write = 1'b0;
    req_addr = 32'h200;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (dut.w_cnt !== 4'd3) begin
      failures++;
      $display("FAIL arst_precond_cnt got=%0d exp=3", dut.w_cnt);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_cs !== 1'b0) begin
      failures++;
      $display("FAIL arst_async got=rdy%b v%b cs%b exp=rdy1 v0 cs0", req_ready, rsp_valid, mem_cs);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_cs !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("FAIL arst_no_stale got=%0d exp=0 bad cycles", stale);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_ready got=%b exp=1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_wait_stall();
    test_issue_stall();
    test_write();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
